// File: rtl/lr_data_mem_dp.sv
// Data memory for the linear-regression datapath: one write port, two registered
// read ports, and a sequential clear FSM that zeroes the array after reset or clr.
module lr_data_mem_dp #(
    parameter int WORD_LEN = 8,
    parameter int MEM_SIZE = 128,
    parameter int ADDR_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [WORD_LEN-1:0] wr_data,
    input  logic                rd_en_a,
    input  logic [ADDR_LEN-1:0] rd_addr_a,
    output logic [WORD_LEN-1:0] rd_data_a,
    output logic                rd_valid_a,
    input  logic                rd_en_b,
    input  logic [ADDR_LEN-1:0] rd_addr_b,
    output logic [WORD_LEN-1:0] rd_data_b,
    output logic                rd_valid_b,
    output logic                addr_err
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_LEN:0] SIZE = (ADDR_LEN+1)'(MEM_SIZE);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(MEM_SIZE - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      clr_ptr, clr_ptr_n;
    logic [WORD_LEN-1:0]   mem [MEM_SIZE];

    logic                  acc_en, wr_in, wr_ok;
    logic [1:0]            rd_en, rd_in, rd_valid;
    logic [1:0][ADDR_LEN-1:0] rd_addr;
    logic [1:0][WORD_LEN-1:0] rd_word, rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_n;
            clr_ptr <= clr_ptr_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_ptr_n = clr_ptr;
        case (state)
            CLEAR: begin
                if (clr) begin
                    clr_ptr_n = '0;
                end else if (clr_ptr == LAST) begin
                    clr_ptr_n = '0;
                    state_n   = READY;
                end else begin
                    clr_ptr_n = clr_ptr + 1'b1;
                end
            end
            READY: begin
                if (clr) begin
                    clr_ptr_n = '0;
                    state_n   = CLEAR;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    assign busy   = (state == CLEAR);
    // clr beats any access issued on the same edge
    assign acc_en = (state == READY) && !clr;
    assign wr_in  = {1'b0, wr_addr} < SIZE;
    assign wr_ok  = acc_en && wr_en && wr_in;

    // Array has no reset; the clear FSM is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (busy && !clr)
            mem[clr_ptr] <= '0;
        else if (wr_ok)
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    assign rd_en   = {rd_en_b, rd_en_a};
    assign rd_addr = {rd_addr_b, rd_addr_a};

    // Write-first bypass; out-of-range reads return zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_in[p]   = {1'b0, rd_addr[p]} < SIZE;
            rd_word[p] = '0;
            if (rd_in[p])
                rd_word[p] = (wr_ok && wr_addr == rd_addr[p]) ? wr_data
                                                             : mem[rd_addr[p][IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
            addr_err <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rd_valid[p] <= acc_en && rd_en[p];
                if (acc_en && rd_en[p])
                    rd_data[p] <= rd_word[p];
            end
            addr_err <= acc_en && ((wr_en && !wr_in) || |(rd_en & ~rd_in));
        end
    end

    assign rd_data_a  = rd_data[0];
    assign rd_data_b  = rd_data[1];
    assign rd_valid_a = rd_valid[0];
    assign rd_valid_b = rd_valid[1];
endmodule

// File: tb/tb_lr_data_mem_dp.sv
// Directed bench for lr_data_mem_dp: clear timing, dual reads, write-first,
// out-of-range handling, clr priority and asynchronous reset.
module tb_lr_data_mem_dp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       busy;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [7:0] rd_addr_a = '0;
    logic [7:0] rd_data_a;
    logic       rd_valid_a;
    logic       rd_en_b = 1'b0;
    logic [7:0] rd_addr_b = '0;
    logic [7:0] rd_data_b;
    logic       rd_valid_b;
    logic       addr_err;

    int checks = 0;
    int passed = 0;

    lr_data_mem_dp #(.WORD_LEN(8), .MEM_SIZE(128), .ADDR_LEN(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr = 1'b0;
    endtask

    // Count edges until busy drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        idle();
        tick(); tick();
        checks++;
        if (busy !== 1'b1 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || addr_err !== 1'b0 ||
            rd_data_a !== 8'h00 || rd_data_b !== 8'h00)
            $display("FAIL reset_state busy=%b va=%b vb=%b err=%b da=%h db=%h expected 1 0 0 0 00 00",
                     busy, rd_valid_a, rd_valid_b, addr_err, rd_data_a, rd_data_b);
        else passed++;
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 128) $display("FAIL reset_busy_len got %0d expected 128", n);
        else passed++;
    endtask

    task automatic test_read_zero();
        logic [7:0] addrs [3] = '{8'd0, 8'd64, 8'd127};
        foreach (addrs[i]) begin
            rd_en_a = 1'b1; rd_addr_a = addrs[i];
            tick();
            rd_en_a = 1'b0;
            checks++;
            if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b1)
                $display("FAIL read_zero[%0d] data=%h valid=%b expected 00 1", addrs[i], rd_data_a, rd_valid_a);
            else passed++;
            tick();
            checks++;
            if (rd_valid_a !== 1'b0) $display("FAIL read_zero_pulse[%0d] valid=%b expected 0", addrs[i], rd_valid_a);
            else passed++;
        end
    endtask

    task automatic test_dual_read();
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 8'd3;
        rd_en_b = 1'b1; rd_addr_b = 8'd3;
        tick();
        idle();
        checks++;
        if (rd_data_a !== 8'hA5 || rd_data_b !== 8'hA5 || rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1)
            $display("FAIL dual_read da=%h db=%h va=%b vb=%b expected a5 a5 1 1",
                     rd_data_a, rd_data_b, rd_valid_a, rd_valid_b);
        else passed++;
        tick();
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || rd_data_a !== 8'hA5)
            $display("FAIL dual_read_pulse va=%b vb=%b da=%h expected 0 0 a5", rd_valid_a, rd_valid_b, rd_data_a);
        else passed++;
    endtask

    task automatic test_write_first();
        wr_en = 1'b1; wr_addr = 8'd10; wr_data = 8'h3C;
        rd_en_a = 1'b1; rd_addr_a = 8'd10;
        tick();
        idle();
        checks++;
        if (rd_data_a !== 8'h3C || rd_valid_a !== 1'b1)
            $display("FAIL write_first data=%h valid=%b expected 3c 1", rd_data_a, rd_valid_a);
        else passed++;
        rd_en_b = 1'b1; rd_addr_b = 8'd10;
        tick();
        idle();
        checks++;
        if (rd_data_b !== 8'h3C || rd_valid_b !== 1'b1)
            $display("FAIL write_first_stored data=%h valid=%b expected 3c 1", rd_data_b, rd_valid_b);
        else passed++;
    endtask

    task automatic test_out_of_range();
        wr_en = 1'b1; wr_addr = 8'd200; wr_data = 8'h77;
        rd_en_b = 1'b1; rd_addr_b = 8'd128;
        tick();
        idle();
        checks++;
        if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b1 || addr_err !== 1'b1)
            $display("FAIL oor_access db=%h vb=%b err=%b expected 00 1 1", rd_data_b, rd_valid_b, addr_err);
        else passed++;
        // 200 must not alias onto 72 (200 mod 128)
        rd_en_a = 1'b1; rd_addr_a = 8'd72;
        tick();
        idle();
        checks++;
        if (addr_err !== 1'b0 || rd_data_a !== 8'h00 || rd_valid_a !== 1'b1)
            $display("FAIL oor_no_alias err=%b da=%h va=%b expected 0 00 1", addr_err, rd_data_a, rd_valid_a);
        else passed++;
        rd_en_a = 1'b1; rd_addr_a = 8'd255;
        tick();
        idle();
        checks++;
        if (addr_err !== 1'b1 || rd_data_a !== 8'h00) $display("FAIL oor_read_a err=%b da=%h expected 1 00", addr_err, rd_data_a);
        else passed++;
        tick();
        checks++;
        if (addr_err !== 1'b0) $display("FAIL oor_err_pulse err=%b expected 0", addr_err);
        else passed++;
    endtask

    task automatic test_clr();
        int n;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 8'd5;
        tick();
        checks++;
        if (rd_data_a !== 8'h06) $display("FAIL clr_prefill da=%h expected 06", rd_data_a);
        else passed++;
        clr = 1'b1; wr_en = 1'b1; wr_addr = 8'd7; wr_data = 8'h99;
        rd_en_a = 1'b1; rd_addr_a = 8'd0;
        tick();
        idle();
        checks++;
        if (busy !== 1'b1 || rd_valid_a !== 1'b0 || rd_data_a !== 8'h06)
            $display("FAIL clr_priority busy=%b va=%b da=%h expected 1 0 06", busy, rd_valid_a, rd_data_a);
        else passed++;
        count_busy(n);
        checks++;
        if (n !== 128) $display("FAIL clr_busy_len got %0d expected 128", n);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 8'(i);
            tick();
            checks++;
            if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b1)
                $display("FAIL clr_contents[%0d] da=%h va=%b expected 00 1", i, rd_data_a, rd_valid_a);
            else passed++;
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        wr_en = 1'b1; wr_addr = 8'd20; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 8'd20;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (40) tick();
        checks++;
        if (rd_data_a !== 8'h5A || busy !== 1'b1) $display("FAIL pre_reset da=%h busy=%b expected 5a 1", rd_data_a, busy);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 ||
            addr_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL async_reset da=%h db=%h va=%b vb=%b err=%b busy=%b expected 00 00 0 0 0 1",
                     rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, addr_err, busy);
        else passed++;
        idle();
        tick();
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 128) $display("FAIL async_reset_busy_len got %0d expected 128", n);
        else passed++;
        rd_en_a = 1'b1; rd_addr_a = 8'd20;
        tick();
        idle();
        checks++;
        if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b1)
            $display("FAIL post_reset_read da=%h va=%b expected 00 1", rd_data_a, rd_valid_a);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_dual_read();
        test_write_first();
        test_out_of_range();
        test_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/lr_data_mem_dp.md
Name: lr_data_mem_dp

Overview:
Parametrised data memory for the linear-regression datapath. It has one synchronous write port and two independent synchronous read ports, so a coefficient and a sample can be fetched in the same cycle. Contents are cleared by a sequential clear state machine instead of a single-cycle bulk reset. Reads are registered and carry a valid strobe, and out-of-range accesses are flagged.

Parameters:
WORD_LEN, 8, data word width in bits
MEM_SIZE, 128, number of words; must be 2..2**ADDR_LEN
ADDR_LEN, 8, address width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous request to re-clear all contents
busy  output  1  high while the clear sequence is running
wr_en  input  1  write strobe
wr_addr  input  ADDR_LEN  write address
wr_data  input  WORD_LEN  write data
rd_en_a  input  1  read strobe, port A
rd_addr_a  input  ADDR_LEN  read address, port A
rd_data_a  output  WORD_LEN  registered read data, port A
rd_valid_a  output  1  one-cycle pulse: rd_data_a updated
rd_en_b  input  1  read strobe, port B
rd_addr_b  input  ADDR_LEN  read address, port B
rd_data_b  output  WORD_LEN  registered read data, port B
rd_valid_b  output  1  one-cycle pulse: rd_data_b updated
addr_err  output  1  one-cycle pulse: an out-of-range access occurred in the previous cycle

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- FSM states are CLEAR and READY.
- rst asserted (async):
  - state = CLEAR, clr_ptr = 0, busy = 1.
  - rd_data_a/b = 0, rd_valid_a/b = 0, addr_err = 0.
  - Memory array is not reset directly.
- CLEAR:
  - Each rising edge with rst low writes 0 to mem[clr_ptr] and increments clr_ptr.
  - The edge that clears mem[MEM_SIZE-1] moves state to READY.
  - busy therefore stays high for exactly MEM_SIZE edges after rst deasserts, then drops.
- clr:
  - Sampled high in READY: state = CLEAR, clr_ptr = 0, busy = 1 on the next edge; memory is not written on that edge.
  - Sampled high in CLEAR: clr_ptr restarts at 0.
- While busy:
  - wr_en, rd_en_a and rd_en_b are ignored.
  - rd_valid_a/b = 0, addr_err = 0, rd_data_a/b hold their value.
- Write (READY):
  - If wr_en and wr_addr < MEM_SIZE, mem[wr_addr] = wr_data at the edge.
  - If wr_addr >= MEM_SIZE, no write occurs.
- Read (READY), per port x:
  - If rd_en_x, then at the edge rd_data_x = mem[rd_addr_x] and rd_valid_x = 1. Latency is 1 cycle.
  - If not rd_en_x, rd_valid_x = 0 and rd_data_x holds (no tri-state, no X).
  - If rd_addr_x >= MEM_SIZE, rd_data_x = 0 and rd_valid_x = 1.
- Read-during-write, same in-range address on the same edge: write-first. rd_data_x = wr_data, and the array is updated.
- Ports A and B may read the same address simultaneously; both return the same word.
- addr_err is registered: 1 on the edge following any enabled out-of-range write or read (either port) while READY, otherwise 0.
- Simultaneous clr and wr_en/rd_en in READY: clr wins. The write is dropped and rd_valid = 0.
- Reset mid-clear or mid-access: outputs go to reset values immediately, and the clear sequence restarts from 0.
- Addresses are compared unsigned and at full ADDR_LEN width; there is no wrap-around.

Test Plan:
- Reset then idle (defaults 8/128/8): busy high for exactly 128 edges after rst falls, then low. Reads of addr 0, 64 and 127 return 0 with rd_valid pulsing for 1 cycle.
- Write 0xA5 to addr 3, then read A addr 3 and read B addr 3 on the same edge: both rd_data = 0xA5 one cycle later, rd_valid_a = rd_valid_b = 1 for one cycle only.
- Same-edge write 0x3C to addr 10 and read A addr 10: rd_data_a = 0x3C. A following read B of addr 10 also returns 0x3C.
- Write to addr 200 and read B of addr 128: no array change, rd_data_b = 0, rd_valid_b = 1, addr_err = 1 for one cycle, then 0.
- Fill addrs 0..5 with 1..6, pulse clr together with wr_en at addr 7: write dropped, busy high 128 cycles. Afterwards addrs 0..7 all read 0.
- Assert rst asynchronously mid-clear (clr_ptr = 40) and mid-read: all outputs 0 immediately, without waiting for a clk edge. After release, busy lasts a full 128 cycles.
